// File: rtl/stage_one_pkg.sv
// rtl/stage_one_pkg.sv - shared types for the stage_one job scheduler
// Job record, scheduler state encoding and the job legality check.
package stage_one_pkg;

  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] k;
    logic [DW-1:0] row;
    logic [DW-1:0] col;
    logic          mode;
  } job_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } sched_state_e;

  // A zero in any shape field would hang or no-op the engine, so such jobs are dropped.
  function automatic logic job_legal(job_t j);
    return (j.k != '0) && (j.row != '0) && (j.col != '0);
  endfunction

endpackage

// File: rtl/stage_one_job_fifo.sv
// rtl/stage_one_job_fifo.sv - synchronous job FIFO, DEPTH entries (power of 2)
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module stage_one_job_fifo
  import stage_one_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  job_t push_data_i,
  input  logic pop_i,
  output job_t pop_data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  job_t          mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/stage_one_sched.sv
// rtl/stage_one_sched.sv - queues shape jobs and launches them one at a time on stage_one_calc
// Optional STAGE_ONE_SCHED_PERF_EN: measures WAIT cycles of each job into last_cycles.
module stage_one_sched
  import stage_one_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [DW-1:0] job_k,
  input  logic [DW-1:0] job_row,
  input  logic [DW-1:0] job_col,
  input  logic          job_mode,
  output logic          calc_start,
  output logic [DW-1:0] calc_k_param,
  output logic [DW-1:0] calc_row_shape,
  output logic [DW-1:0] calc_col_shape,
  output logic          calc_out_mode,
  input  logic          calc_done,
  output logic          busy,
  output logic          job_done,
  output logic [CW-1:0] done_cnt,
  output logic [CW-1:0] skip_cnt,
  output logic [31:0]   last_cycles
);

  sched_state_e  state_q, state_d;
  job_t          cfg_q, cfg_d;
  logic [CW-1:0] done_cnt_q, done_cnt_d;
  logic [CW-1:0] skip_cnt_q, skip_cnt_d;

  job_t          push_job;
  job_t          head_job;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;

  assign push_job = '{k: job_k, row: job_row, col: job_col, mode: job_mode};

  stage_one_job_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (job_valid),
    .push_data_i (push_job),
    .pop_i       (fifo_pop),
    .pop_data_o  (head_job),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    done_cnt_d = done_cnt_q;
    skip_cnt_d = skip_cnt_q;
    fifo_pop   = 1'b0;
    calc_start = 1'b0;
    job_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (job_legal(head_job)) begin
            cfg_d   = head_job;
            state_d = S_LAUNCH;
          end else begin
            skip_cnt_d = skip_cnt_q + CW'(1);
          end
        end
      end
      S_LAUNCH: begin
        calc_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (calc_done) state_d = S_DONE;
      end
      S_DONE: begin
        job_done   = 1'b1;
        done_cnt_d = done_cnt_q + CW'(1);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cfg_q      <= '0;
      done_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      done_cnt_q <= done_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  // Ready is forced low during reset so every output reads zero while rst is held.
  assign job_ready      = !fifo_full && !rst;
  assign busy           = (state_q != S_IDLE) || !fifo_empty;
  assign calc_k_param   = cfg_q.k;
  assign calc_row_shape = cfg_q.row;
  assign calc_col_shape = cfg_q.col;
  assign calc_out_mode  = cfg_q.mode;
  assign done_cnt       = done_cnt_q;
  assign skip_cnt       = skip_cnt_q;

`ifdef STAGE_ONE_SCHED_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;
  logic [31:0] last_cycles_q, last_cycles_d;

  always_comb begin
    perf_cnt_d    = perf_cnt_q;
    last_cycles_d = last_cycles_q;
    case (state_q)
      S_LAUNCH: perf_cnt_d = '0;
      S_WAIT:   if (perf_cnt_q != '1) perf_cnt_d = perf_cnt_q + 32'd1;
      S_DONE:   last_cycles_d = perf_cnt_q;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_q    <= '0;
      last_cycles_q <= '0;
    end else begin
      perf_cnt_q    <= perf_cnt_d;
      last_cycles_q <= last_cycles_d;
    end
  end

  assign last_cycles = last_cycles_q;
`else
  assign last_cycles = '0;
`endif

endmodule
